encode_sample_scheduler: RTL and testbench

//  Sequences encoder sampling for the precise-encode interpolator.
//  - Every programmed period it runs a req/ack read of the raw W (spindle) and X (linear) encoders.
//  - It delivers each sample as a one-cycle encode_update_o pulse with the W/X values.
//  - It issues x_zero_flag_o so the interpolator re-arms at scan start and scan stop.
//  - It substitutes held samples for missed reads, and latches a fault after repeated misses.

---
 rtl/pcg_encode_pkg.sv | 16 +
 rtl/encode_period_timer.sv | 40 ++++
 rtl/encode_sample_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_encode_sample_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcg_encode_pkg.sv
// Shared definitions for the precise-encode path: sample width, default period
// and the sampling scheduler state encoding.
package pcg_encode_pkg;

   localparam int ENCODE_WID     = 32;
   localparam int DEFAULT_PERIOD = 4000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_REQ       = 3'd2,
      ST_CHECK     = 3'd3,
      ST_FAULT     = 3'd4
   } enc_state_e;

endpackage

// File: rtl/encode_period_timer.sv
// Loadable down-counter: ticks for one cycle at zero and reloads the latched
// value, so consecutive ticks are exactly (load value + 1) enabled cycles apart.
module encode_period_timer #(
   parameter int WID = 16
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           load_i,
   input  logic [WID-1:0] load_val_i,
   input  logic           en_i,
   output logic           tick_o
);

   logic [WID-1:0] cnt_q, cnt_d;
   logic [WID-1:0] reload_q;

   assign tick_o = en_i && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = (cnt_q == '0) ? reload_q : cnt_q - WID'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q    <= '0;
         reload_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (load_i) begin
            reload_q <= load_val_i;
         end
      end
   end

endmodule

// File: rtl/encode_sample_scheduler.sv
// Periodic W/X encoder sampler with held-sample substitution and miss fault.
// Optional statistics counters are built when ENC_SAMPLE_STAT_EN is defined.
module encode_sample_scheduler
   import pcg_encode_pkg::*;
#(
   parameter int ENCODE_WID  = pcg_encode_pkg::ENCODE_WID,
   parameter int PERIOD_WID  = 16,
   parameter int MIN_PERIOD  = 64,
   parameter int ACK_TIMEOUT = 32,
   parameter int MAX_MISS    = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  scan_start_i,
   input  logic                  scan_stop_i,
   input  logic [PERIOD_WID-1:0] period_cfg_i,
   input  logic                  fault_clr_i,
   output logic                  enc_req_o,
   input  logic                  enc_ack_i,
   input  logic [ENCODE_WID-1:0] enc_w_i,
   input  logic [ENCODE_WID-1:0] enc_x_i,
   output logic                  encode_update_o,
   output logic [ENCODE_WID-1:0] encode_w_o,
   output logic [ENCODE_WID-1:0] encode_x_o,
   output logic                  x_zero_flag_o,
   output logic                  busy_o,
   output logic                  fault_o,
   output logic [2:0]            state_o
`ifdef ENC_SAMPLE_STAT_EN
   ,
   output logic [31:0]           stat_sample_cnt_o,
   output logic [15:0]           stat_miss_cnt_o,
   output logic [15:0]           stat_overrun_cnt_o
`endif
);

   localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
   localparam int MISS_W = $clog2(MAX_MISS + 1);
   localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(ACK_TIMEOUT);
   localparam logic [MISS_W-1:0]     MISS_MAX = MISS_W'(MAX_MISS);
   localparam logic [PERIOD_WID-1:0] MIN_P    = PERIOD_WID'(MIN_PERIOD);

   enc_state_e            state_q;
   logic                  req_q;
   logic                  update_q;
   logic                  xzero_q;
   logic                  busy_q;
   logic                  fault_q;
   logic [ENCODE_WID-1:0] w_q;
   logic [ENCODE_WID-1:0] x_q;
   logic [TO_W-1:0]       to_cnt_q;
   logic [MISS_W-1:0]     miss_q;

   logic                  start_go;
   logic                  busy_state;
   logic                  timeout_hit;
   logic                  tick;
   logic [PERIOD_WID-1:0] p_eff;
   logic [PERIOD_WID-1:0] p_load;
   logic [MISS_W-1:0]     miss_inc;
   logic                  miss_trip;

   assign busy_state  = (state_q == ST_WAIT_TICK) || (state_q == ST_REQ) ||
                        (state_q == ST_CHECK);
   assign start_go    = (state_q == ST_IDLE) && scan_start_i && !scan_stop_i;
   assign p_eff       = (period_cfg_i < MIN_P) ? MIN_P : period_cfg_i;
   assign p_load      = p_eff - PERIOD_WID'(1);
   assign timeout_hit = (to_cnt_q == TO_LAST);
   assign miss_inc    = (miss_q == MISS_MAX) ? miss_q : miss_q + MISS_W'(1);
   assign miss_trip   = (miss_inc == MISS_MAX);

   // The period keeps counting through REQ and CHECK so sample spacing stays
   // exactly P; a tick arriving outside WAIT_TICK is simply not acted on.
   encode_period_timer #(
      .WID (PERIOD_WID)
   ) u_period_timer (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (start_go),
      .load_val_i (p_load),
      .en_i       (busy_state),
      .tick_o     (tick)
   );

   // Handshake: enc_req_o rises on entry to REQ and stays high until an ack is
   // sampled or the timeout expires; enc_ack_i is only looked at in REQ, so an
   // ack with enc_req_o low is ignored and one request at most is outstanding.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         update_q <= 1'b0;
         xzero_q  <= 1'b0;
         busy_q   <= 1'b0;
         fault_q  <= 1'b0;
         w_q      <= '0;
         x_q      <= '0;
         to_cnt_q <= '0;
         miss_q   <= '0;
      end else begin
         update_q <= 1'b0;
         xzero_q  <= 1'b0;
         if (busy_state && scan_stop_i) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            xzero_q  <= 1'b1;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_go) begin
                     state_q  <= ST_REQ;
                     req_q    <= 1'b1;
                     xzero_q  <= 1'b1;
                     busy_q   <= 1'b1;
                     miss_q   <= '0;
                     to_cnt_q <= '0;
                  end
               end
               ST_WAIT_TICK: begin
                  if (tick) begin
                     state_q  <= ST_REQ;
                     req_q    <= 1'b1;
                     to_cnt_q <= '0;
                  end
               end
               ST_REQ: begin
                  if (enc_ack_i) begin
                     state_q  <= ST_CHECK;
                     req_q    <= 1'b0;
                     update_q <= 1'b1;
                     w_q      <= enc_w_i;
                     x_q      <= enc_x_i;
                     miss_q   <= '0;
                  end else if (timeout_hit) begin
                     // A miss re-presents the held sample unless it trips the fault.
                     state_q  <= ST_CHECK;
                     req_q    <= 1'b0;
                     update_q <= !miss_trip;
                     miss_q   <= miss_inc;
                  end else begin
                     to_cnt_q <= to_cnt_q + TO_W'(1);
                  end
               end
               ST_CHECK: begin
                  if (miss_q == MISS_MAX) begin
                     state_q <= ST_FAULT;
                     fault_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_WAIT_TICK;
                  end
               end
               ST_FAULT: begin
                  if (fault_clr_i) begin
                     state_q <= ST_IDLE;
                     fault_q <= 1'b0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign enc_req_o       = req_q;
   assign encode_update_o = update_q;
   assign encode_w_o      = w_q;
   assign encode_x_o      = x_q;
   assign x_zero_flag_o   = xzero_q;
   assign busy_o          = busy_q;
   assign fault_o         = fault_q;
   assign state_o         = state_q;

`ifdef ENC_SAMPLE_STAT_EN
   logic [31:0] stat_sample_q;
   logic [15:0] stat_miss_q;
   logic [15:0] stat_overrun_q;
   logic        good_rd;
   logic        miss_ev;
   logic        overrun_ev;

   assign good_rd    = (state_q == ST_REQ) && enc_ack_i && !scan_stop_i;
   assign miss_ev    = (state_q == ST_REQ) && !enc_ack_i && timeout_hit && !scan_stop_i;
   assign overrun_ev = tick && ((state_q == ST_REQ) || (state_q == ST_CHECK));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || start_go) begin
         stat_sample_q  <= '0;
         stat_miss_q    <= '0;
         stat_overrun_q <= '0;
      end else begin
         if (good_rd) begin
            stat_sample_q <= stat_sample_q + 32'd1;
         end
         if (miss_ev) begin
            stat_miss_q <= stat_miss_q + 16'd1;
         end
         if (overrun_ev) begin
            stat_overrun_q <= stat_overrun_q + 16'd1;
         end
      end
   end

   assign stat_sample_cnt_o  = stat_sample_q;
   assign stat_miss_cnt_o    = stat_miss_q;
   assign stat_overrun_cnt_o = stat_overrun_q;
`endif

endmodule

// File: tb/tb_encode_sample_scheduler.sv
// Bench for encode_sample_scheduler: encoder responder feeding a scoreboard of
// expected strobes (value, latency), plus directed stop/fault/reset scenarios.
module tb_encode_sample_scheduler;
   import pcg_encode_pkg::*;

   localparam int W        = 32;
   localparam int PW       = 16;
   localparam int ACK_TO   = 32;
   localparam int MAX_MISS = 3;
   localparam int EXP_W    = 8 + 2 * W;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          scan_start_i;
   logic          scan_stop_i;
   logic [PW-1:0] period_cfg_i;
   logic          fault_clr_i;
   logic          enc_req_o;
   logic          enc_ack_i;
   logic [W-1:0]  enc_w_i;
   logic [W-1:0]  enc_x_i;
   logic          encode_update_o;
   logic [W-1:0]  encode_w_o;
   logic [W-1:0]  encode_x_o;
   logic          x_zero_flag_o;
   logic          busy_o;
   logic          fault_o;
   logic [2:0]    state_o;
`ifdef ENC_SAMPLE_STAT_EN
   logic [31:0]   stat_sample_cnt_o;
   logic [15:0]   stat_miss_cnt_o;
   logic [15:0]   stat_overrun_cnt_o;
`endif

   // clock / reset
   always #5 clk_i = ~clk_i;

   encode_sample_scheduler dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .scan_start_i    (scan_start_i),
      .scan_stop_i     (scan_stop_i),
      .period_cfg_i    (period_cfg_i),
      .fault_clr_i     (fault_clr_i),
      .enc_req_o       (enc_req_o),
      .enc_ack_i       (enc_ack_i),
      .enc_w_i         (enc_w_i),
      .enc_x_i         (enc_x_i),
      .encode_update_o (encode_update_o),
      .encode_w_o      (encode_w_o),
      .encode_x_o      (encode_x_o),
      .x_zero_flag_o   (x_zero_flag_o),
      .busy_o          (busy_o),
      .fault_o         (fault_o),
      .state_o         (state_o)
`ifdef ENC_SAMPLE_STAT_EN
      ,
      .stat_sample_cnt_o  (stat_sample_cnt_o),
      .stat_miss_cnt_o    (stat_miss_cnt_o),
      .stat_overrun_cnt_o (stat_overrun_cnt_o)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard state: {latency from req rise, W, X}
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] e;
   int           ack_delay  = 3;
   int           drop_n     = 0;
   bit           resp_en    = 1'b1;
   bit           rand_delay = 1'b0;
   logic [W-1:0] next_w     = 32'h0000_0100;
   logic [W-1:0] next_x     = 32'hFFFF_FF00;
   logic [W-1:0] last_w     = '0;
   logic [W-1:0] last_x     = '0;
   int           consec     = 0;
   bit           exp_fault  = 1'b0;
   bit           req_prev   = 1'b0;
   bit           cur_drop   = 1'b0;
   int           req_age    = 0;
   int           cur_delay  = 0;
   int           ncyc       = 0;
   int           rise_cyc   = 0;
   int           strobe_cnt = 0;
   int           strobe_cyc = 0;
   int           strobe_prv = 0;
   int           xz_cnt     = 0;

   // monitor + encoder responder, both on the falling edge
   initial begin
      enc_ack_i = 1'b0;
      enc_w_i   = '0;
      enc_x_i   = '0;
      forever begin
         @(negedge clk_i);
         ncyc++;
         if (x_zero_flag_o) xz_cnt++;
         if (enc_req_o && !req_prev) rise_cyc = ncyc;
         if (encode_update_o) begin
            strobe_cnt++;
            strobe_prv = strobe_cyc;
            strobe_cyc = ncyc;
            check("strobe_req_low", 64'(enc_req_o), 64'(0));
            if (exp_q.size() == 0) begin
               check("strobe_unexpected", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("strobe_w", 64'(encode_w_o), 64'(e[63:32]));
               check("strobe_x", 64'(encode_x_o), 64'(e[31:0]));
               check("strobe_lat", 64'(ncyc - rise_cyc), 64'(e[71:64]));
            end
         end
         enc_ack_i = 1'b0;
         if (resp_en && enc_req_o) begin
            if (!req_prev) begin
               req_age   = 0;
               cur_drop  = (drop_n > 0);
               if (cur_drop) drop_n--;
               cur_delay = rand_delay ? int'($urandom_range(0, ACK_TO)) : ack_delay;
            end else begin
               req_age++;
            end
            if (!cur_drop && req_age == cur_delay) begin
               enc_ack_i = 1'b1;
               enc_w_i   = next_w;
               enc_x_i   = next_x;
               exp_q.push_back({8'(cur_delay + 1), next_w, next_x});
               last_w    = next_w;
               last_x    = next_x;
               consec    = 0;
               next_w    = next_w + 32'h0000_0100;
               next_x    = next_x - 32'h0000_0033;
            end else if (cur_drop && req_age == ACK_TO) begin
               consec++;
               if (consec >= MAX_MISS) exp_fault = 1'b1;
               else exp_q.push_back({8'(ACK_TO + 1), last_w, last_x});
            end
         end
         req_prev = enc_req_o;
      end
   end

   // driver tasks
   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk_i);
         #1;
      end
   endtask

   task automatic start_scan(input logic [PW-1:0] p);
      consec       = 0;
      period_cfg_i = p;
      scan_start_i = 1'b1;
      step();
      scan_start_i = 1'b0;
   endtask

   task automatic stop_scan(input string tag);
      scan_stop_i = 1'b1;
      step();
      scan_stop_i = 1'b0;
      check({tag, "_stop_state"}, 64'(state_o), 64'(ST_IDLE));
      check({tag, "_stop_req"}, 64'(enc_req_o), 64'(0));
      check({tag, "_stop_busy"}, 64'(busy_o), 64'(0));
      check({tag, "_stop_xzero"}, 64'(x_zero_flag_o), 64'(1));
   endtask

   task automatic wait_strobes(input int n, input int budget, input string tag);
      int target;
      int k;
      target = strobe_cnt + n;
      k = 0;
      while (strobe_cnt < target && k < budget) begin
         step();
         k++;
      end
      if (strobe_cnt < target) check({tag, "_timeout"}, 64'(strobe_cnt), 64'(target));
   endtask

   int xz0;
   int s0;
   int k;

   initial begin
      rst_n_i      = 1'b0;
      scan_start_i = 1'b0;
      scan_stop_i  = 1'b0;
      fault_clr_i  = 1'b0;
      period_cfg_i = PW'(DEFAULT_PERIOD);
      step(3);
      check("rst_req", 64'(enc_req_o), 64'(0));
      check("rst_update", 64'(encode_update_o), 64'(0));
      check("rst_xzero", 64'(x_zero_flag_o), 64'(0));
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_fault", 64'(fault_o), 64'(0));
      check("rst_w", 64'(encode_w_o), 64'(0));
      check("rst_state", 64'(state_o), 64'(ST_IDLE));
      rst_n_i = 1'b1;
      step(2);

      // 1: default period, ack 3 cycles after req
      xz0 = xz_cnt;
      start_scan(PW'(DEFAULT_PERIOD));
      check("t1_xzero", 64'(x_zero_flag_o), 64'(1));
      check("t1_req_now", 64'(enc_req_o), 64'(1));
      check("t1_busy", 64'(busy_o), 64'(1));
      wait_strobes(2, 4200, "t1_a");
      check("t1_spacing_a", 64'(strobe_cyc - strobe_prv), 64'(DEFAULT_PERIOD));
      wait_strobes(1, 4100, "t1_b");
      check("t1_spacing_b", 64'(strobe_cyc - strobe_prv), 64'(DEFAULT_PERIOD));
      check("t1_xzero_cnt", 64'(xz_cnt - xz0), 64'(1));
      stop_scan("t1");
      check("t1_exp_empty", 64'(exp_q.size()), 64'(0));

      // 2: clamp to 64, start while busy ignored
      start_scan(PW'(10));
      wait_strobes(1, 200, "t2_a");
      xz0 = xz_cnt;
      period_cfg_i = PW'(200);
      scan_start_i = 1'b1;
      step();
      scan_start_i = 1'b0;
      wait_strobes(2, 300, "t2_b");
      check("t2_spacing", 64'(strobe_cyc - strobe_prv), 64'(64));
      check("t2_no_rearm", 64'(xz_cnt - xz0), 64'(0));
      stop_scan("t2");
      check("t2_exp_empty", 64'(exp_q.size()), 64'(0));

      // 3: single miss, then good ack clears the count
      start_scan(PW'(64));
      wait_strobes(1, 200, "t3_a");
      drop_n = 1;
      wait_strobes(2, 300, "t3_b");
      drop_n = 2;
      wait_strobes(3, 400, "t3_c");
      check("t3_no_fault", 64'(fault_o), 64'(exp_fault));
      check("t3_busy", 64'(busy_o), 64'(1));
      stop_scan("t3");
      check("t3_exp_empty", 64'(exp_q.size()), 64'(0));

      // 4: three consecutive misses trip the fault
      drop_n = 3;
      s0 = strobe_cnt;
      start_scan(PW'(64));
      k = 0;
      while (!fault_o && k < 400) begin
         step();
         k++;
      end
      check("t4_fault", 64'(fault_o), 64'(exp_fault));
      check("t4_busy", 64'(busy_o), 64'(0));
      check("t4_state", 64'(state_o), 64'(ST_FAULT));
      check("t4_held_strobes", 64'(strobe_cnt - s0), 64'(MAX_MISS - 1));
      scan_start_i = 1'b1;
      step();
      scan_start_i = 1'b0;
      step();
      check("t4_start_ignored", 64'(state_o), 64'(ST_FAULT));
      check("t4_no_req", 64'(enc_req_o), 64'(0));
      fault_clr_i = 1'b1;
      step();
      fault_clr_i = 1'b0;
      exp_fault = 1'b0;
      check("t4_clr_fault", 64'(fault_o), 64'(0));
      check("t4_clr_state", 64'(state_o), 64'(ST_IDLE));
      check("t4_exp_empty", 64'(exp_q.size()), 64'(0));

      // 5: start+stop together, stop during REQ with a late ack
      xz0 = xz_cnt;
      s0  = strobe_cnt;
      period_cfg_i = PW'(64);
      scan_start_i = 1'b1;
      scan_stop_i  = 1'b1;
      step();
      scan_start_i = 1'b0;
      scan_stop_i  = 1'b0;
      step(5);
      check("t5_both_state", 64'(state_o), 64'(ST_IDLE));
      check("t5_both_req", 64'(enc_req_o), 64'(0));
      check("t5_both_xzero", 64'(xz_cnt - xz0), 64'(0));
      resp_en = 1'b0;
      start_scan(PW'(64));
      step(2);
      check("t5_in_req", 64'(state_o), 64'(ST_REQ));
      stop_scan("t5");
      enc_w_i   = 32'hDEAD_BEEF;
      enc_x_i   = 32'h8000_0001;
      enc_ack_i = 1'b1;
      step(6);
      check("t5_late_no_strobe", 64'(strobe_cnt - s0), 64'(0));
      check("t5_late_w_held", 64'(encode_w_o), 64'(last_w));
      check("t5_late_state", 64'(state_o), 64'(ST_IDLE));

      // 6: reset pulse while in REQ
      start_scan(PW'(64));
      step(2);
      check("t6_in_req", 64'(state_o), 64'(ST_REQ));
      rst_n_i = 1'b0;
      step();
      rst_n_i = 1'b1;
      last_w  = '0;
      last_x  = '0;
      check("t6_req", 64'(enc_req_o), 64'(0));
      check("t6_busy", 64'(busy_o), 64'(0));
      check("t6_w", 64'(encode_w_o), 64'(0));
      check("t6_x", 64'(encode_x_o), 64'(0));
      check("t6_state", 64'(state_o), 64'(ST_IDLE));
      enc_ack_i = 1'b1;
      step(4);
      check("t6_stale_state", 64'(state_o), 64'(ST_IDLE));
      check("t6_stale_w", 64'(encode_w_o), 64'(0));
      resp_en = 1'b1;

      // 7: random ack delays including the timeout boundary
      rand_delay = 1'b1;
      start_scan(PW'($urandom_range(64, 90)));
      wait_strobes(8, 1200, "t7");
      check("t7_no_fault", 64'(fault_o), 64'(exp_fault));
      stop_scan("t7");
      rand_delay = 1'b0;
      check("t7_exp_empty", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
